// File: rtl/inv_substitute_pkg.sv
// Shared AES definitions for the decryption datapath.
//   aes_byte_t  : one state byte
//   aes_state_t : 16-byte state, byte 15 = first byte (row 0, col 0)
//   INV_SBOX    : 256-entry inverse S-box, indexed by the input byte value
package inv_substitute_pkg;

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t [15:0] aes_state_t;

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_substitute_sbox.sv
// Combinational inverse S-box lookup, one byte in, one byte out.
//   in_byte  : byte to substitute
//   out_byte : INV_SBOX[in_byte]
module inv_sbox
    import inv_substitute_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Constant-table index; synthesis folds this into a 256-entry ROM case.
    always_comb begin
        out_byte = INV_SBOX[in_byte];
    end

endmodule

// File: rtl/inv_substitute.sv
// Registered AES-128 inverse SubBytes stage (one pipeline register).
//   clk, rst_n : rising-edge clock, async active-low reset
//   in_valid   : state carries a valid block this cycle
//   state      : input state, byte 15 first
//   out_valid  : newstate carries a valid result
//   newstate   : bytewise inverse-substituted state, held while idle
module inv_substitute
    import inv_substitute_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0][7:0] state,
    output logic             out_valid,
    output logic [15:0][7:0] newstate
);

    aes_state_t sub_state;
    aes_state_t newstate_d, newstate_q;
    logic       out_valid_d, out_valid_q;

    // 16 independent lookups, byte position preserved.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (state[i]),
            .out_byte (sub_state[i])
        );
    end

    always_comb begin
        newstate_d  = newstate_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            newstate_d = sub_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            newstate_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            newstate_q  <= newstate_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign newstate  = newstate_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_substitute.sv
module tb_inv_substitute;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [15:0][7:0] state;
    logic             out_valid;
    logic [15:0][7:0] newstate;

    int checks = 0;
    int errors = 0;

    inv_substitute dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .state     (state),
        .out_valid (out_valid),
        .newstate  (newstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward S-box; the expected inverse is derived from it.
    logic [7:0] sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    logic [7:0] inv_ref [256];

    typedef struct {
        logic         vin;
        logic [127:0] sin;
        logic         vexp;
        logic [127:0] sexp;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] inv_state(input logic [127:0] s);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = inv_ref[s[b*8 +: 8]];
        return r;
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] blk [4];
    logic [127:0] held;
    logic [127:0] tmp;

    initial begin
        for (int i = 0; i < 256; i++) inv_ref[sbox[i]] = 8'(i);

        vecs[0] = '{1'b1, 128'hd4e0b81e27bfb44111985d52aef1e530,
                    1'b1, 128'h19a09ae93df4c6f8e3e28d48be2b2a08};
        vecs[1] = '{1'b1, 128'h0, 1'b1, {16{8'h52}}};
        vecs[2] = '{1'b1, {16{8'hff}}, 1'b1, {16{8'h7d}}};
        vecs[3] = '{1'b1, 128'h0001637cffd42711ae00000000000000,
                    1'b1, 128'h520900017d193de3be52525252525252};
        vecs[4] = '{1'b0, 128'h0123456789abcdef0123456789abcdef,
                    1'b0, 128'h520900017d193de3be52525252525252};
        vecs[5] = '{1'b1, 128'h63636363636363636363636363636363,
                    1'b1, 128'h0};

        in_valid = 1'b0;
        state    = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_newstate", newstate, 128'h0);
        chk("reset_valid", {127'h0, out_valid}, 128'h0);
        #20 rst_n = 1'b1;
        step();
        chk("post_reset_idle_valid", {127'h0, out_valid}, 128'h0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].vin;
            state    = vecs[i].sin;
            step();
            chk($sformatf("vec%0d_valid", i), {127'h0, out_valid}, {127'h0, vecs[i].vexp});
            chk($sformatf("vec%0d_state", i), newstate, vecs[i].sexp);
        end

        // Exhaustive: each byte value replicated across all positions
        for (int x = 0; x < 256; x++) begin
            in_valid = 1'b1;
            state    = {16{8'(x)}};
            step();
            chk($sformatf("exh_%02h", x), newstate, {16{inv_ref[x]}});
            tmp = '0;
            for (int b = 0; b < 16; b++) tmp[b*8 +: 8] = sbox[newstate[b]];
            chk($sformatf("exh_rt_%02h", x), tmp, {16{8'(x)}});
        end

        // Position independence
        for (int k = 0; k < 16; k++) begin
            tmp = '0;
            tmp[k*8 +: 8] = 8'h63;
            state = tmp;
            step();
            tmp = {16{8'h52}};
            tmp[k*8 +: 8] = 8'h00;
            chk($sformatf("pos_%0d", k), newstate, tmp);
        end

        // Streaming: 4 back-to-back blocks
        blk[0] = 128'h00112233445566778899aabbccddeeff;
        blk[1] = 128'hdeadbeefcafef00d0123456789abcdef;
        blk[2] = 128'h3243f6a8885a308d313198a2e0370734;
        blk[3] = 128'hfedcba98765432100f1e2d3c4b5a6978;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            state    = blk[i];
            step();
            chk($sformatf("stream%0d_valid", i), {127'h0, out_valid}, 128'h1);
            chk($sformatf("stream%0d_state", i), newstate, inv_state(blk[i]));
        end
        in_valid = 1'b0;
        state    = blk[0];
        step();
        chk("stream_drop_valid", {127'h0, out_valid}, 128'h0);
        chk("stream_drop_hold", newstate, inv_state(blk[3]));

        // Idle with changing state
        held = inv_state(blk[3]);
        for (int i = 0; i < 4; i++) begin
            state = {4{32'($urandom)}};
            step();
            chk($sformatf("idle%0d_valid", i), {127'h0, out_valid}, 128'h0);
            chk($sformatf("idle%0d_hold", i), newstate, held);
        end

        // Reset mid-stream
        in_valid = 1'b1;
        state    = blk[2];
        step();
        chk("pre_rst_valid", {127'h0, out_valid}, 128'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", newstate, 128'h0);
        chk("midrst_valid", {127'h0, out_valid}, 128'h0);
        step();
        chk("inrst_state", newstate, 128'h0);
        #3 rst_n = 1'b1;
        state = blk[1];
        step();
        chk("after_rst_valid", {127'h0, out_valid}, 128'h1);
        chk("after_rst_state", newstate, inv_state(blk[1]));
        in_valid = 1'b0;
        step();
        chk("after_rst_drop", {127'h0, out_valid}, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
